// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO PHY responder: FSM state codes, register
// map, register reset values, opcodes and the preamble length.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN shortens the preamble to one bit.
package mdio_pkg;

  typedef logic [2:0] mdio_state_t;

  localparam mdio_state_t S_IDLE  = 3'd0;
  localparam mdio_state_t S_ST    = 3'd1;
  localparam mdio_state_t S_OP    = 3'd2;
  localparam mdio_state_t S_PHYAD = 3'd3;
  localparam mdio_state_t S_REGAD = 3'd4;
  localparam mdio_state_t S_TA    = 3'd5;
  localparam mdio_state_t S_RDATA = 3'd6;
  localparam mdio_state_t S_WDATA = 3'd7;

  localparam logic [4:0] REG_BMCR = 5'd0;
  localparam logic [4:0] REG_BMSR = 5'd1;
  localparam logic [4:0] REG_ID1  = 5'd2;
  localparam logic [4:0] REG_ID2  = 5'd3;
  localparam logic [4:0] REG_ANAR = 5'd4;

  localparam logic [15:0] BMCR_DEFAULT = 16'h3100;
  localparam logic [15:0] ANAR_DEFAULT = 16'h01E1;
  localparam logic [15:0] BMSR_BASE    = 16'h7809;

  localparam int BMCR_RESET_BIT = 15;
  localparam int BMCR_LOOP_BIT  = 14;
  localparam int BMCR_SPEED_BIT = 13;
  localparam int BMCR_DUPLEX_BIT = 8;
  localparam int BMSR_LINK_BIT  = 2;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PREAMBLE_LEN = 6'd1;
`else
  localparam logic [5:0] PREAMBLE_LEN = 6'd32;
`endif

endpackage

// File: rtl/mdio_phy_regfile.sv
// MII register file: BMCR/ANAR storage, BMCR soft-reset, read mux and
// registered configuration outputs.
module mdio_phy_regfile
  import mdio_pkg::*;
#(
  parameter logic [15:0] PHY_ID1 = 16'h0022,
  parameter logic [15:0] PHY_ID2 = 16'h1561
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [4:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic        link_up,
  output logic        cfg_loopback,
  output logic        cfg_speed100,
  output logic        cfg_duplex
);

  logic [15:0] bmcr;
  logic [15:0] anar;

  // Writable registers; a BMCR write with the reset bit restores both to defaults.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bmcr <= BMCR_DEFAULT;
      anar <= ANAR_DEFAULT;
    end else if (wr_en) begin
      if (wr_addr == REG_BMCR) begin
        if (wr_data[BMCR_RESET_BIT]) begin
          bmcr <= BMCR_DEFAULT;
          anar <= ANAR_DEFAULT;
        end else begin
          bmcr <= wr_data;
        end
      end else if (wr_addr == REG_ANAR) begin
        anar <= wr_data;
      end
    end
  end

  // Read mux; the BMCR reset bit always reads back as 0.
  always_comb begin
    rd_data = 16'h0000;
    case (rd_addr)
      REG_BMCR: rd_data = bmcr & 16'h7FFF;
      REG_BMSR: rd_data = BMSR_BASE | ({15'd0, link_up} << BMSR_LINK_BIT);
      REG_ID1:  rd_data = PHY_ID1;
      REG_ID2:  rd_data = PHY_ID2;
      REG_ANAR: rd_data = anar;
      default:  rd_data = 16'h0000;
    endcase
  end

  // Registered copies of the BMCR control bits.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cfg_loopback <= BMCR_DEFAULT[BMCR_LOOP_BIT];
      cfg_speed100 <= BMCR_DEFAULT[BMCR_SPEED_BIT];
      cfg_duplex   <= BMCR_DEFAULT[BMCR_DUPLEX_BIT];
    end else begin
      cfg_loopback <= bmcr[BMCR_LOOP_BIT];
      cfg_speed100 <= bmcr[BMCR_SPEED_BIT];
      cfg_duplex   <= bmcr[BMCR_DUPLEX_BIT];
    end
  end

endmodule

// File: rtl/mdio_phy_responder.sv
// MDIO (clause 22) PHY-side responder. Oversamples mdc/mdio on the system
// clock and decodes frames on synchronized mdc rising edges.
// Build option: MDIO_PREAMBLE_SUPPRESS_EN allows frames after a 1-bit preamble.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | counting preamble ones, waiting for the first start bit
// ST    | expecting the second start bit (1)
// OP    | collecting the 2-bit opcode
// PHYAD | shifting in the 5-bit PHY address
// REGAD | shifting in the 5-bit register address
// TA    | turnaround; on a matched read, drive 0 on the second bit
// RDATA | driving 16 data bits, then releasing the line
// WDATA | shifting in 16 data bits, committing on the last
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0022,
  parameter logic [15:0] PHY_ID2  = 16'h1561
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mdc,
  input  logic       mdio_i,
  output logic       mdio_o,
  output logic       mdio_oe,
  input  logic       link_up,
  output logic       cfg_loopback,
  output logic       cfg_speed100,
  output logic       cfg_duplex,
  output logic       reg_wr,
  output logic [4:0] reg_wr_addr
);

  logic        mdc_s1, mdc_s2, mdc_prev;
  logic        mdio_s1, mdio_s2;
  logic        mdc_rise;
  logic        bit_in;

  mdio_state_t state;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic        op_first;
  logic        op_rd;
  logic [3:0]  addr_sh;
  logic        phy_match;
  logic [4:0]  reg_addr;
  logic [15:0] data_sh;
  logic [15:0] rd_data;
  logic        wr_commit;
  logic [15:0] wr_data;

  // Two-flop synchronizers plus an mdc history flop for edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mdc_s1   <= 1'b0;
      mdc_s2   <= 1'b0;
      mdc_prev <= 1'b0;
      mdio_s1  <= 1'b0;
      mdio_s2  <= 1'b0;
    end else begin
      mdc_s1   <= mdc;
      mdc_s2   <= mdc_s1;
      mdc_prev <= mdc_s2;
      mdio_s1  <= mdio_i;
      mdio_s2  <= mdio_s1;
    end
  end

  assign mdc_rise = mdc_s2 & ~mdc_prev;
  assign bit_in   = mdio_s2;

  // The regfile write happens on the same clock as the last data bit is seen.
  assign wr_commit = mdc_rise && (state == S_WDATA) && (bit_cnt == 5'd15) && phy_match;
  assign wr_data   = {data_sh[14:0], bit_in};

  // Frame decoder and line driver.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      pre_cnt     <= 6'd0;
      bit_cnt     <= 5'd0;
      op_first    <= 1'b0;
      op_rd       <= 1'b0;
      addr_sh     <= 4'd0;
      phy_match   <= 1'b0;
      reg_addr    <= 5'd0;
      data_sh     <= 16'd0;
      mdio_oe     <= 1'b0;
      mdio_o      <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 5'd0;
    end else begin
      reg_wr <= 1'b0;
      if (mdc_rise) begin
        case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PREAMBLE_LEN) pre_cnt <= pre_cnt + 6'd1;
            end else if (pre_cnt == PREAMBLE_LEN) begin
              state   <= S_ST;
              pre_cnt <= 6'd0;
            end else begin
              pre_cnt <= 6'd0;
            end
          end
          S_ST: begin
            bit_cnt <= 5'd0;
            pre_cnt <= 6'd0;
            state   <= bit_in ? S_OP : S_IDLE;
          end
          S_OP: begin
            if (bit_cnt == 5'd0) begin
              op_first <= bit_in;
              bit_cnt  <= 5'd1;
            end else begin
              bit_cnt <= 5'd0;
              if ({op_first, bit_in} == OP_READ) begin
                op_rd <= 1'b1;
                state <= S_PHYAD;
              end else if ({op_first, bit_in} == OP_WRITE) begin
                op_rd <= 1'b0;
                state <= S_PHYAD;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_PHYAD: begin
            addr_sh <= {addr_sh[2:0], bit_in};
            if (bit_cnt == 5'd4) begin
              bit_cnt   <= 5'd0;
              phy_match <= ({addr_sh, bit_in} == PHY_ADDR);
              state     <= S_REGAD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_REGAD: begin
            addr_sh <= {addr_sh[2:0], bit_in};
            if (bit_cnt == 5'd4) begin
              bit_cnt  <= 5'd0;
              reg_addr <= {addr_sh, bit_in};
              state    <= S_TA;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
              mdio_oe <= 1'b0;
            end else begin
              bit_cnt <= 5'd0;
              if (op_rd) begin
                state   <= S_RDATA;
                data_sh <= rd_data;
                if (phy_match) begin
                  mdio_oe <= 1'b1;
                  mdio_o  <= 1'b0;
                end
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (bit_cnt == 5'd16) begin
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b0;
              bit_cnt <= 5'd0;
              state   <= S_IDLE;
            end else begin
              if (phy_match) mdio_o <= data_sh[15];
              data_sh <= {data_sh[14:0], 1'b0};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_WDATA: begin
            data_sh <= wr_data;
            if (bit_cnt == 5'd15) begin
              bit_cnt <= 5'd0;
              pre_cnt <= 6'd0;
              state   <= S_IDLE;
              if (phy_match) begin
                reg_wr      <= 1'b1;
                reg_wr_addr <= reg_addr;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  mdio_phy_regfile #(
    .PHY_ID1 (PHY_ID1),
    .PHY_ID2 (PHY_ID2)
  ) u_regfile (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_commit),
    .wr_addr      (reg_addr),
    .wr_data      (wr_data),
    .rd_addr      (reg_addr),
    .rd_data      (rd_data),
    .link_up      (link_up),
    .cfg_loopback (cfg_loopback),
    .cfg_speed100 (cfg_speed100),
    .cfg_duplex   (cfg_duplex)
  );

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: directed frame table, corner sequences and
// randomized frames checked against a register-level model.
module tb_mdio_phy_responder;

  localparam logic [4:0] PHY = 5'd1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int PRE_THR = 1;
`else
  localparam int PRE_THR = 32;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mdc = 1'b0;
  logic       mdio_i = 1'b1;
  logic       mdio_o, mdio_oe;
  logic       link_up = 1'b1;
  logic       cfg_loopback, cfg_speed100, cfg_duplex;
  logic       reg_wr;
  logic [4:0] reg_wr_addr;

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;

  logic [15:0] m_bmcr = 16'h3100;
  logic [15:0] m_anar = 16'h01E1;

  mdio_phy_responder dut (
    .clock        (clock),
    .reset        (reset),
    .mdc          (mdc),
    .mdio_i       (mdio_i),
    .mdio_o       (mdio_o),
    .mdio_oe      (mdio_oe),
    .link_up      (link_up),
    .cfg_loopback (cfg_loopback),
    .cfg_speed100 (cfg_speed100),
    .cfg_duplex   (cfg_duplex),
    .reg_wr       (reg_wr),
    .reg_wr_addr  (reg_wr_addr)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (reg_wr === 1'b1) wr_pulses <= wr_pulses + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a, input logic lk);
    case (a)
      5'd0: return m_bmcr & 16'h7FFF;
      5'd1: return 16'h7809 | (lk ? 16'h0004 : 16'h0000);
      5'd2: return 16'h0022;
      5'd3: return 16'h1561;
      5'd4: return m_anar;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) begin
      if (d[15]) begin
        m_bmcr = 16'h3100;
        m_anar = 16'h01E1;
      end else m_bmcr = d;
    end else if (a == 5'd4) m_anar = d;
  endtask

  task automatic check_cfg(input string name);
    check(name, {29'd0, cfg_loopback, cfg_speed100, cfg_duplex},
          {29'd0, m_bmcr[14], m_bmcr[13], m_bmcr[8]});
  endtask

  // One MAC-side bit: data set while mdc is low, response sampled late in the high phase.
  task automatic mdc_bit(input logic b);
    mdio_i = b;
    mdc = 1'b0;
    #50;
    mdc = 1'b1;
    #50;
  endtask

  // Drives a full frame (or aborts it with a reset at edge abort_edge) and checks the line.
  task automatic do_frame(input logic is_rd, input logic [4:0] phy, input logic [4:0] ra,
                          input logic [15:0] wd, input int pre, input logic [15:0] exp_rd,
                          input logic exp_wr, input int abort_edge, input string tag);
    logic bits [0:127];
    int n = 0;
    int t0;
    logic drive;
    int line_err = 0;
    logic [15:0] got = 16'h0;
    int pulses0 = wr_pulses;
    for (int i = 0; i < pre; i++) bits[n++] = 1'b1;
    bits[n++] = 1'b0;
    bits[n++] = 1'b1;
    bits[n++] = is_rd ? 1'b1 : 1'b0;
    bits[n++] = is_rd ? 1'b0 : 1'b1;
    for (int i = 4; i >= 0; i--) bits[n++] = phy[i];
    for (int i = 4; i >= 0; i--) bits[n++] = ra[i];
    t0 = n;
    bits[n++] = 1'b1;
    bits[n++] = is_rd ? 1'b1 : 1'b0;
    for (int i = 15; i >= 0; i--) bits[n++] = is_rd ? 1'b1 : wd[i];
    bits[n++] = 1'b0;
    bits[n++] = 1'b0;
    drive = is_rd && (phy == PHY) && (pre >= PRE_THR);
    for (int e = 0; e < n; e++) begin
      logic eoe;
      mdc_bit(bits[e]);
      eoe = drive && (e >= t0 + 1) && (e <= t0 + 17);
      if (mdio_oe !== eoe) line_err++;
      if (eoe && e == t0 + 1 && mdio_o !== 1'b0) line_err++;
      if (e >= t0 + 2 && e <= t0 + 17) got[15 - (e - t0 - 2)] = mdio_o;
      if (e == abort_edge) begin
        reset = 1'b0;
        @(posedge clock); #1;
        check({tag, "_oe_in_reset"}, {31'd0, mdio_oe}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        m_bmcr = 16'h3100;
        m_anar = 16'h01E1;
        check({tag, "_line"}, line_err, 0);
        check({tag, "_wr_pulses"}, wr_pulses - pulses0, 0);
        return;
      end
    end
    check({tag, "_line"}, line_err, 0);
    if (drive) check({tag, "_rdata"}, {16'd0, got}, {16'd0, exp_rd});
    check({tag, "_wr_pulses"}, wr_pulses - pulses0, exp_wr ? 1 : 0);
    if (exp_wr) check({tag, "_wr_addr"}, {27'd0, reg_wr_addr}, {27'd0, ra});
  endtask

  typedef struct {
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [0:19];

  initial begin
    vecs[0]  = '{1'b1, 5'd1, 5'd2, 16'h0000, 16'h0022, 1'b0};
    vecs[1]  = '{1'b1, 5'd1, 5'd3, 16'h0000, 16'h1561, 1'b0};
    vecs[2]  = '{1'b1, 5'd1, 5'd0, 16'h0000, 16'h3100, 1'b0};
    vecs[3]  = '{1'b1, 5'd1, 5'd1, 16'h0000, 16'h780D, 1'b0};
    vecs[4]  = '{1'b0, 5'd1, 5'd4, 16'h05E1, 16'h0000, 1'b1};
    vecs[5]  = '{1'b1, 5'd1, 5'd4, 16'h0000, 16'h05E1, 1'b0};
    vecs[6]  = '{1'b0, 5'd1, 5'd0, 16'hC000, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 5'd1, 5'd0, 16'h0000, 16'h3100, 1'b0};
    vecs[8]  = '{1'b1, 5'd1, 5'd4, 16'h0000, 16'h01E1, 1'b0};
    vecs[9]  = '{1'b1, 5'd3, 5'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 5'd3, 5'd4, 16'hFFFF, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 5'd1, 5'd4, 16'h0000, 16'h01E1, 1'b0};
    vecs[12] = '{1'b0, 5'd1, 5'd2, 16'hABCD, 16'h0000, 1'b1};
    vecs[13] = '{1'b1, 5'd1, 5'd2, 16'h0000, 16'h0022, 1'b0};
    vecs[14] = '{1'b0, 5'd1, 5'd9, 16'h1234, 16'h0000, 1'b1};
    vecs[15] = '{1'b1, 5'd1, 5'd9, 16'h0000, 16'h0000, 1'b0};
    vecs[16] = '{1'b0, 5'd1, 5'd0, 16'h4100, 16'h0000, 1'b1};
    vecs[17] = '{1'b1, 5'd1, 5'd0, 16'h0000, 16'h4100, 1'b0};
    vecs[18] = '{1'b0, 5'd1, 5'd0, 16'h8000, 16'h0000, 1'b1};
    vecs[19] = '{1'b1, 5'd1, 5'd0, 16'h0000, 16'h3100, 1'b0};

    repeat (4) @(posedge clock);
    #1;
    check("reset_oe", {31'd0, mdio_oe}, 32'd0);
    check("reset_o", {31'd0, mdio_o}, 32'd0);
    check("reset_wr", {26'd0, reg_wr, reg_wr_addr}, 32'd0);
    check_cfg("reset_cfg");
    reset = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < 20; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_frame(vecs[i].rd, vecs[i].phy, vecs[i].ra, vecs[i].wd, 32,
               vecs[i].exp_rd, vecs[i].exp_wr, -1, tag);
      if (vecs[i].exp_wr) model_write(vecs[i].ra, vecs[i].wd);
      check_cfg({tag, "_cfg"});
    end

    // 31-bit preamble: accepted only when preamble suppression is built in.
    do_frame(1'b1, 5'd1, 5'd3, 16'h0, 31, 16'h1561, 1'b0, -1, "pre31");

    // Reset during the 9th read data bit, then a clean frame.
    do_frame(1'b0, 5'd1, 5'd4, 16'h0155, 32, 16'h0, 1'b1, -1, "pre_abort_wr");
    model_write(5'd4, 16'h0155);
    do_frame(1'b1, 5'd1, 5'd4, 16'h0, 32, 16'h0155, 1'b0, 32 + 14 + 10, "abort");
    do_frame(1'b1, 5'd1, 5'd4, 16'h0, 32, 16'h01E1, 1'b0, -1, "post_abort");
    check_cfg("post_abort_cfg");

    for (int i = 0; i < 24; i++) begin
      logic rd, wr_ok;
      logic [4:0] phy, ra;
      logic [15:0] wd, er;
      string tag;
      tag = $sformatf("rnd%0d", i);
      link_up = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      phy = ($urandom_range(0, 3) != 0) ? PHY : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      wd = 16'($urandom);
      er = model_read(ra, link_up);
      wr_ok = !rd && (phy == PHY);
      do_frame(rd, phy, ra, wd, 32, er, wr_ok, -1, tag);
      if (wr_ok) model_write(ra, wd);
      check_cfg({tag, "_cfg"});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 SHALL provide parameter PHY_ADDR, default 5'd1, the PHY address this responder answers to.
REQ-002 SHALL provide parameter PHY_ID1, default 16'h0022, the read value of register 2.
REQ-003 SHALL provide parameter PHY_ID2, default 16'h1561, the read value of register 3.
REQ-004 SHALL have port clock  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port mdc  input  1  management clock from the MAC, asynchronous to clock.
REQ-007 SHALL have port mdio_i  input  1  MDIO line value, asynchronous to clock.
REQ-008 SHALL have port mdio_o  output  1  MDIO drive value.
REQ-009 SHALL have port mdio_oe  output  1  MDIO drive enable; 1 means this block drives the line.
REQ-010 SHALL have port link_up  input  1  link status, shown in BMSR bit 2.
REQ-011 SHALL have port cfg_loopback  output  1  BMCR bit 14.
REQ-012 SHALL have port cfg_speed100  output  1  BMCR bit 13.
REQ-013 SHALL have port cfg_duplex  output  1  BMCR bit 8.
REQ-014 SHALL have port reg_wr  output  1  one-cycle pulse when an addressed write commits.
REQ-015 SHALL have port reg_wr_addr  output  5  register address of the last committed write.

Function
REQ-016 SHALL pass mdc and mdio_i through 2-flop synchronizers; a rising edge of mdc is detected when the synchronized mdc is 1 and its previous value was 0.
REQ-017 SHALL act only on detected mdc rising edges; correct operation requires clock frequency to be at least 4x mdc.
REQ-018 SHALL use the FSM states IDLE, ST, OP, PHYAD, REGAD, TA, RDATA and WDATA.
REQ-019 IDLE: SHALL count consecutive sampled 1s, saturating at 32; any sampled 0 with count below 32 SHALL clear the count.
REQ-020 IDLE to ST: SHALL occur on a sampled 0 when the count is 32; in ST, a sampled 1 SHALL go to OP, and a sampled 0 SHALL go to IDLE with the count cleared.
REQ-021 OP: SHALL take 2 bits; 10 means read and 01 means write; 00 or 11 SHALL go to IDLE.
REQ-022 PHYAD and REGAD: SHALL shift in 5 bits each, MSB first; the address matches when PHYAD equals PHY_ADDR.
REQ-023 TA (read, address match), first TA edge: mdio_oe SHALL be 0.
REQ-024 TA (read, address match), second TA edge: mdio_oe SHALL be 1 and mdio_o SHALL be 0.
REQ-025 TA (write): SHALL ignore both TA bits.
REQ-026 RDATA: SHALL drive the register value MSB first, updating on each mdc rising edge; the value is captured at the second TA edge.
REQ-027 After the 16th read bit, the next mdc rising edge SHALL set mdio_oe to 0 and return to IDLE.
REQ-028 WDATA: SHALL shift in 16 bits; on the 16th bit with address match, the write SHALL commit in the same cycle, pulse reg_wr, update reg_wr_addr, then go to IDLE with the count cleared.
REQ-029 Address mismatch: the FSM SHALL still track the whole frame, but mdio_oe SHALL stay 0 and no write SHALL commit.
REQ-030 Reg 0 (BMCR) SHALL be read/write with default 16'h3100; bit 15 is self-clearing.
REQ-031 Writing BMCR with bit 15 set SHALL restore regs 0 and 4 to their defaults on the next cycle, and bit 15 SHALL read 0.
REQ-032 Reg 1 (BMSR) SHALL be read-only and read 16'h7809 OR (link_up << 2).
REQ-033 Regs 2 and 3 SHALL be read-only and read PHY_ID1 and PHY_ID2.
REQ-034 Reg 4 (ANAR) SHALL be read/write with default 16'h01E1.
REQ-035 Regs 5-31 SHALL read 16'h0000 and ignore writes; writes to read-only regs SHALL be ignored but still pulse reg_wr.
REQ-036 cfg_* outputs SHALL be registered copies of the BMCR bits.

Reset
REQ-037 While reset is 0 at a clock edge: state SHALL be IDLE, the count 0, mdio_oe 0, mdio_o 0, reg_wr 0, reg_wr_addr 0, BMCR 16'h3100, ANAR 16'h01E1, and synchronizers cleared.
REQ-038 Reset asserted mid-frame SHALL abort the frame; the line SHALL be released in the reset cycle, and no partial write SHALL commit.

Configuration
REQ-039 With MDIO_PREAMBLE_SUPPRESS_EN defined, IDLE to ST SHALL be allowed after at least 1 sampled 1, and REQ-019's threshold of 32 SHALL become 1.
REQ-040 Without MDIO_PREAMBLE_SUPPRESS_EN, the full 32-bit preamble SHALL be required.

Structure
REQ-041 Shared package mdio_pkg SHALL hold the FSM state enum, register address constants, register default values, the OP code constants and the preamble length.
REQ-042 Sub-module mdio_phy_regfile SHALL hold the register storage, read mux, self-clear and cfg_* outputs; the FSM SHALL stay in the top module.

Verification
REQ-043 Preamble 32x1, then read PHYAD=1 REGAD=2 -> mdio_oe stays 0 on the first TA edge, line driven 0 on the second TA edge, data 16'h0022, line released after the last bit.
REQ-044 Write PHYAD=1 REGAD=4 data 16'h05E1, then read reg 4 -> reg_wr pulses once with reg_wr_addr=4, and the read returns 16'h05E1.
REQ-045 Write BMCR 16'hC000, then read BMCR -> cfg_loopback=0, and the read returns 16'h3100.
REQ-046 Read with PHYAD=3 -> mdio_oe is 0 for the whole frame, and no reg_wr pulse.
REQ-047 31 ones then ST, with the macro undefined -> frame ignored; with the macro defined, the same stimulus -> frame accepted.
REQ-048 Reset pulsed during RDATA bit 8 -> mdio_oe is 0 in the reset cycle, and the next full frame completes normally.
